// File: rtl/led_chaser_pkg.sv
// rtl/led_chaser_pkg.sv - shared types and seed helper for the LED running-light driver
package led_chaser_pkg;

   typedef enum logic [1:0] {
      LEFT     = 2'd0,
      RIGHT    = 2'd1,
      PINGPONG = 2'd2,
      FILL     = 2'd3
   } chase_mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } chase_state_t;

   // First pattern shown after start; RIGHT runs from the top LED down.
   function automatic logic [31:0] seed(chase_mode_t m, int unsigned w);
      logic [31:0] s;
      s = 32'd1;
      if (m == RIGHT) s = 32'd1 << (w - 1);
      return s;
   endfunction

endpackage

// File: rtl/led_chaser_if.sv
// rtl/led_chaser_if.sv - button/mode inputs and LED outputs of the running-light driver
interface led_chaser_if
   import led_chaser_pkg::*;
#(
   parameter int LED_W = 8
);
   logic             start;
   logic             stop;
   chase_mode_t      mode;
   logic [LED_W-1:0] led;
   logic             running;
   logic             step;

   modport master (output start, stop, mode, input led, running, step);
   modport slave  (input start, stop, mode, output led, running, step);
endinterface

// File: rtl/led_chaser_tick_gen.sv
// rtl/led_chaser_tick_gen.sv - free-running divider, one-cycle pulse at terminal count
module tick_gen #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == TERM) ? '0 : cnt + CNT_W'(1);
      end
   end

   assign tick = en && (cnt == TERM);
endmodule

// File: rtl/led_chaser.sv
// rtl/led_chaser.sv - LED running-light FSM: LEFT/RIGHT/PINGPONG/FILL patterns, start/stop control.
// Optional LED_CHASER_SYNC_EN adds 2-flop synchronisers on start and stop.
module led_chaser
   import led_chaser_pkg::*;
#(
   parameter int LED_W    = 8,
   parameter int TICK_DIV = 100_000_000
) (
   input logic          clk,
   input logic          rst,
   led_chaser_if.slave  bus
);
   chase_state_t     state, state_nxt;
   chase_mode_t      mode_q, mode_nxt;
   logic             dir_up, dir_nxt;
   logic [LED_W-1:0] led_q, led_nxt;
   logic [LED_W-1:0] adv, seed_lat;
   logic             adv_dir;
   logic             onehot, thermo, going_up;
   logic             start_use, stop_use;
   logic             cnt_en, tick;

`ifdef LED_CHASER_SYNC_EN
   logic [1:0] start_ff, stop_ff;

   always_ff @(posedge clk) begin
      if (rst) begin
         start_ff <= '0;
         stop_ff  <= '0;
      end else begin
         start_ff <= {start_ff[0], bus.start};
         stop_ff  <= {stop_ff[0], bus.stop};
      end
   end

   assign start_use = start_ff[1];
   assign stop_use  = stop_ff[1];
`else
   assign start_use = bus.start;
   assign stop_use  = bus.stop;
`endif

   // Counter only runs in RUN; a stop clears it in the same cycle it suppresses the step.
   assign cnt_en = (state == RUN) && !stop_use;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (!cnt_en),
      .en   (cnt_en),
      .tick (tick)
   );

   always_comb begin
      seed_lat = LED_W'(seed(mode_q, LED_W));
      onehot   = (led_q != '0) && ((led_q & (led_q - LED_W'(1))) == '0);
      thermo   = (led_q != '0) && ((led_q & (led_q + LED_W'(1))) == '0);
      // An end LED forces the turn even if the direction flag was disturbed.
      going_up = (dir_up && !led_q[LED_W-1]) || led_q[0];
      adv      = seed_lat;
      adv_dir  = 1'b1;
      case (mode_q)
         LEFT:     if (onehot) adv = {led_q[LED_W-2:0], led_q[LED_W-1]};
         RIGHT:    if (onehot) adv = {led_q[0], led_q[LED_W-1:1]};
         PINGPONG: if (onehot) begin
            adv     = going_up ? (led_q << 1) : (led_q >> 1);
            adv_dir = going_up ? !adv[LED_W-1] : adv[0];
         end
         FILL:     if (thermo && !(&led_q)) adv = {led_q[LED_W-2:0], 1'b1};
         default:  adv = seed_lat;
      endcase
   end

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      dir_nxt   = dir_up;
      led_nxt   = led_q;
      case (state)
         IDLE: begin
            led_nxt = '0;
            if (start_use && !stop_use) begin
               state_nxt = RUN;
               mode_nxt  = bus.mode;
               led_nxt   = LED_W'(seed(bus.mode, LED_W));
               dir_nxt   = 1'b1;
            end
         end
         RUN: begin
            if (stop_use) begin
               state_nxt = IDLE;
               led_nxt   = '0;
            end else if (tick) begin
               led_nxt = adv;
               dir_nxt = adv_dir;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mode_q <= LEFT;
         dir_up <= 1'b1;
         led_q  <= '0;
      end else begin
         state  <= state_nxt;
         mode_q <= mode_nxt;
         dir_up <= dir_nxt;
         led_q  <= led_nxt;
      end
   end

   assign bus.led     = led_q;
   assign bus.running = (state == RUN);
   assign bus.step    = tick && !rst;
endmodule

// File: doc/led_chaser.md
# led_chaser

Parametrised running-light driver for the board LED bank, replacing the fixed 8-bit, single-pattern flowing light. It runs in the board clock domain and sits between the push-button inputs and the LED pins. It holds the LEDs dark until started, then advances a pattern once every `TICK_DIV` clocks. The pattern is one of four selectable modes: shift-left wrap, shift-right wrap, ping-pong, or fill bar. A stop input returns it to dark.

## Interface
- `LED_W`, 8: LED count. Legal range is 2..32.
- `TICK_DIV`, 100_000_000: clocks per pattern step. Legal range is ≥ 2.
- `CNT_W`, `$clog2(TICK_DIV)`: tick counter width (derived).
- `clk` input 1: board clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level button. Sampled every cycle.
- `stop` input 1: level button. Sampled every cycle.
- `mode` input 2: pattern select. 0 = LEFT, 1 = RIGHT, 2 = PINGPONG, 3 = FILL. Latched only when leaving IDLE.
- `led` output `LED_W`: LED drive, active-high.
- `running` output 1: high while in RUN.
- `step` output 1: one-cycle pulse on the cycle `led` advances.

## Operation
- **States:** IDLE and RUN.
- **Reset:** `rst` high at a clock edge forces the following, which take effect from the next cycle:
  - state = IDLE
  - `led` = 0
  - `running` = 0
  - `step` = 0
  - tick counter = 0
  - direction = up
  - latched mode = LEFT
  - Reset mid-RUN behaves identically.
- **IDLE:**
  - `led` held at 0.
  - If `start`=1 and `stop`=0: go to RUN, latch `mode`, clear the counter, and load the seed.
  - Seed values:
    - LEFT, PINGPONG, FILL: bit 0 set, i.e. `{0..0,1}`.
    - RIGHT: MSB set, i.e. `{1,0..0}`.
  - PINGPONG also sets direction = up.
- **RUN:**
  - The counter increments each cycle.
  - When counter == `TICK_DIV`-1, the counter goes to 0, `step` pulses, and `led` advances according to the latched mode.
- **Advance rules:**
  - LEFT: `led` rotate left by 1. MSB wraps to bit 0.
  - RIGHT: `led` rotate right by 1. Bit 0 wraps to MSB.
  - PINGPONG: going up, shift left; on the step that makes MSB set, direction becomes down. Going down, shift right; on the step that makes bit 0 set, direction becomes up. Exactly one bit is ever lit. The end LEDs are lit for one step each, not two.
  - FILL: `led` = `{led[W-2:0],1}`. When `led` is all ones, the next step loads `{0..0,1}`.
- **Stop:** `stop`=1 in RUN → IDLE, `led`=0, `running`=0 next cycle, counter cleared.
  - `stop` has priority over `start` and over a coincident step: no `step` pulse is issued.
  - `start` while in RUN is ignored, as is any `mode` change.
- **Out-of-pattern recovery:** any `led` value outside the legal pattern set in RUN (e.g. SEU) is replaced by the seed at the next step.

## Timing
- Start sampled at edge N → `led` = seed and `running`=1 at N+1.
- First advance occurs with `step` high during cycle N+`TICK_DIV`, and `led` changes at edge N+`TICK_DIV`+1. Every subsequent advance follows exactly `TICK_DIV` cycles after the previous one.
- `step` and the new `led` value are registered together: `step` high in the cycle before `led` updates.
- Stop latency is 1 cycle. Restart after stop is allowed on the very next cycle.
- Pattern periods:
  - LEFT and RIGHT: `LED_W` steps.
  - PINGPONG: 2·`LED_W`−2 steps.
  - FILL: `LED_W` steps.

## Configuration
- `LED_CHASER_SYNC_EN`:
  - **When defined:** `start` and `stop` each pass through a 2-flop synchroniser, reset to 0, before use. This adds 2 cycles to start/stop latency (start at edge N → seed at N+3). `mode` is not synchronised and must be stable for ≥3 cycles around `start`.
  - **When undefined:** inputs are used directly, with the latencies given in Timing.

## Structure
- Package `led_chaser_pkg`:
  - typedef `chase_mode_t` (LEFT/RIGHT/PINGPONG/FILL, 2 bits).
  - typedef `chase_state_t` (IDLE/RUN).
  - function `seed(mode, W)`.
- Sub-module `tick_gen`:
  - Parameter `TICK_DIV`.
  - Ports: `clk`, `rst`, `clr`, `en` → `tick`.
  - Free counter, terminal-count pulse.
  - Reused by later display blocks.
- Top level holds the FSM, pattern register, direction flag, and the optional synchroniser.

## Test plan
All tests use `LED_W`=8 and `TICK_DIV`=4.
- **Reset:** `rst`=1 for 3 cycles with `start`=1 → `led`=0x00, `running`=0, and no `step` throughout. Release reset → seed 0x01 one cycle later.
- **LEFT:** start with mode=0 → `led` = 0x01, 0x02 … 0x80, 0x01, each value held 4 cycles. `step` pulses every 4th cycle.
- **RIGHT and FILL:**
  - mode=1 → 0x80, 0x40 … 0x01, 0x80.
  - mode=3 → 0x01, 0x03, 0x07 … 0xFF, 0x01.
- **PINGPONG:** mode=2 → 0x01, 0x02 … 0x80, 0x40 … 0x01, 0x02. The period is 14 steps.
- **Stop and priority:**
  - `stop` asserted on the same cycle as a step → next cycle `led`=0x00 and no `step` pulse.
  - `start`=`stop`=1 in IDLE → remains IDLE.
  - Mode change in RUN → pattern unchanged.
- **Reset mid-run and sync:**
  - `rst` at `led`=0x10 → 0x00 next cycle.
  - With `LED_CHASER_SYNC_EN`, `start` at edge N → 0x01 at N+3.
